dp_layer_scheduler: RTL
=======================

Name: dp_layer_scheduler

Overview:
Sequences one shared DotProduct engine across all neurons of a fully connected MLP layer. Per neuron: selects the weight row, restarts the engine through its active-high reset, waits for end-of-computation and writes the 32-bit float result to the layer output buffer. Sits between the layer-level controller (start/done) and the DotProduct datapath, weight ROM and output RAM.

Parameters:
NEURONS, 10, neurons in the layer (dot products per job); legal range ≥1.
RST_CYCLES, 2, cycles dp_rst is held high before each dot product; legal range ≥1.
TIMEOUT, 4096, max cycles in RUN waiting for dp_endf before an error is raised.
IDX_W, $clog2(NEURONS) (min 1), width of neuron index/address.

Ports:
CLK  in  1  clock; all state updates on its rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  one-cycle job request; honoured only in IDLE, DONE or ERR.
busy  out  1  high from the cycle after an accepted start until DONE/ERR is entered.
done  out  1  one-cycle pulse when the last result is written.
err  out  1  sticky timeout flag; cleared by the next accepted start or by reset.
row_sel  out  IDX_W  weight-row/neuron index presented to the weight ROM feeding the engine.
dp_rst  out  1  active-high reset to the DotProduct engine.
dp_endf  in  1  engine end-of-computation flag; level, stays high until the engine is reset.
dp_result  in  32  engine IEEE-754 single-precision result.
out_we  out  1  output buffer write strobe.
out_addr  out  IDX_W  output buffer address (= neuron index).
out_data  out  32  value written.

Behaviour:
- Reset values: busy=0, done=0, err=0, row_sel=0, dp_rst=1, out_we=0, out_addr=0, out_data=0. State=IDLE. Counters=0.
- The engine is held in reset (dp_rst=1) in every state except RUN.
- FSM states: IDLE, CLEAR, RUN, WRITE, NEXT, DONE, ERR.
- IDLE/DONE/ERR + start → CLEAR. Also sets row_sel=0, err=0, busy=1.
- CLEAR: dp_rst=1 for exactly RST_CYCLES cycles (cycle counter), then → RUN.
- RUN: dp_rst=0 and cycle counter counts up.
  - dp_endf is ignored in the first RUN cycle; this guards against a stale flag.
  - dp_endf=1 on a later cycle → WRITE, and dp_result is captured into out_data on that edge.
  - Counter reaching TIMEOUT with no dp_endf → ERR.
- WRITE: out_we=1 for one cycle with out_addr=row_sel and out_data=captured value; → NEXT.
- NEXT: if row_sel==NEURONS-1 → DONE; else row_sel+1 → CLEAR.
- DONE: done=1 for its first cycle only, busy=0. Stays in DONE until start.
- ERR: err=1 (sticky), busy=0, dp_rst=1, no further writes. row_sel holds the failing index.
- Latency per neuron = RST_CYCLES + engine cycles + 1 (capture) + 1 (WRITE) + 1 (NEXT). Job done pulse follows the last NEXT by one cycle.
- start while busy: ignored, with no effect on state or counters.
- start and dp_endf in the same cycle: dp_endf handling per state; start still ignored.
- NEURONS=1: single pass; NEXT goes directly to DONE.
- Reset mid-job (any state): immediate return to reset values, dp_rst=1, no partial write completes.
- row_sel never exceeds NEURONS-1; no wrap-around.

Optional Feature:
ACT_RELU_EN.
- Defined: the captured value passes through a ReLU before out_data. If dp_result[31]==1 (negative, incl. -0.0), out_data=32'h0000_0000; else unchanged. NaN with sign set is also zeroed.
- Undefined: out_data=dp_result verbatim. Timing is identical in both builds.

Decomposition:
- Shared package mlp_pkg: FSM state encoding, FP_W=32 constant, FP_ZERO constant, relu function (used by the scheduler under ACT_RELU_EN).
- One natural sub-module: dp_sched_timer, a loadable down/up cycle counter shared by CLEAR (RST_CYCLES) and RUN (TIMEOUT), with expire output.
- FSM and output registers stay in the top module.

Test Plan:
- NEURONS=3, engine model asserts dp_endf 50 cycles after dp_rst falls, results 3F800000/40000000/C0400000 → three out_we pulses at addr 0,1,2 with those values (third =00000000 with ACT_RELU_EN); done pulses once; busy low after.
- Stale flag: dp_endf held high at RUN entry for 1 cycle, then low, real endf at cycle 20 → only the real endf captured; exactly one write per neuron.
- Timeout: TIMEOUT=64, engine never asserts dp_endf on neuron 1 → err=1 after 64 RUN cycles, row_sel=1, no write for addr 1; next start clears err and restarts at row 0.
- Start during busy: pulse start mid-RUN of neuron 0 → no restart, write sequence unchanged.
- Async reset asserted mid-RUN of neuron 2 (between clock edges) → outputs at reset values immediately, dp_rst=1, no out_we; new start runs full job.
- NEURONS=1, RST_CYCLES=1 → single write at addr 0; done exactly RST_CYCLES+engine+3 cycles after start accepted.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared types and helpers for the MLP layer datapath: scheduler FSM states,
// float word width and the ReLU used on captured dot-product results.
package mlp_pkg;

    localparam int FP_W = 32;
    localparam logic [FP_W-1:0] FP_ZERO = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_WRITE,
        S_NEXT,
        S_DONE,
        S_ERR
    } sched_state_t;

    // Any value with the sign bit set (negatives, -0.0, negative NaN) is zeroed.
    function automatic logic [FP_W-1:0] relu(input logic [FP_W-1:0] x);
        return x[FP_W-1] ? FP_ZERO : x;
    endfunction

endpackage

// File: rtl/dp_sched_timer.sv
// Loadable cycle counter shared by the scheduler's reset hold (counts down to
// zero) and its run watchdog (counts up to a limit); expire flags either end.
module dp_sched_timer #(
    parameter int W = 12
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         load,
    input  logic         up,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         expire
);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (up) begin
            count <= count + 1'b1;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    always_comb begin
        expire = up ? (count == limit) : (count == '0);
    end

endmodule

// File: rtl/dp_layer_scheduler.sv
// Runs one shared DotProduct engine over every neuron of an MLP layer and
// stores each result. Optional build macro ACT_RELU_EN applies ReLU on capture.
module dp_layer_scheduler
    import mlp_pkg::*;
#(
    parameter int NEURONS    = 10,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 4096,
    parameter int IDX_W      = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [IDX_W-1:0] row_sel,
    output logic             dp_rst,
    input  logic             dp_endf,
    input  logic [FP_W-1:0]  dp_result,
    output logic             out_we,
    output logic [IDX_W-1:0] out_addr,
    output logic [FP_W-1:0]  out_data
);

    localparam int CNT_MAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LIMIT = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_ROW  = IDX_W'(NEURONS - 1);

    sched_state_t     state, next_state;
    logic [IDX_W-1:0] row_next;
    logic             tmr_load;
    logic             tmr_up;
    logic [CNT_W-1:0] tmr_val;
    logic [CNT_W-1:0] tmr_count;
    logic             tmr_expire;
    logic             capture;
    logic [FP_W-1:0]  cap_value;

    dp_sched_timer #(.W(CNT_W)) u_timer (
        .CLK      (CLK),
        .reset    (reset),
        .load     (tmr_load),
        .up       (tmr_up),
        .load_val (tmr_val),
        .limit    (RUN_LIMIT),
        .count    (tmr_count),
        .expire   (tmr_expire)
    );

    always_comb begin
`ifdef ACT_RELU_EN
        cap_value = relu(dp_result);
`else
        cap_value = dp_result;
`endif
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            row_sel  <= '0;
            out_data <= FP_ZERO;
            done     <= 1'b0;
        end else begin
            state   <= next_state;
            row_sel <= row_next;
            done    <= (state == S_NEXT) && (next_state == S_DONE);
            if (capture) begin
                out_data <= cap_value;
            end
        end
    end

    always_comb begin
        next_state = state;
        row_next   = row_sel;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        capture    = 1'b0;
        tmr_up     = (state == S_RUN);
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    next_state = S_CLEAR;
                    row_next   = '0;
                    tmr_load   = 1'b1;
                    tmr_val    = RST_LOAD;
                end
            end
            S_CLEAR: begin
                if (tmr_expire) begin
                    next_state = S_RUN;
                    tmr_load   = 1'b1;
                    tmr_val    = '0;
                end
            end
            S_RUN: begin
                // A flag seen on the first RUN cycle may predate the engine reset.
                if (dp_endf && (tmr_count != '0)) begin
                    next_state = S_WRITE;
                    capture    = 1'b1;
                end else if (tmr_expire) begin
                    next_state = S_ERR;
                end
            end
            S_WRITE: begin
                next_state = S_NEXT;
            end
            S_NEXT: begin
                if (row_sel == LAST_ROW) begin
                    next_state = S_DONE;
                end else begin
                    next_state = S_CLEAR;
                    row_next   = row_sel + 1'b1;
                    tmr_load   = 1'b1;
                    tmr_val    = RST_LOAD;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy     = (state == S_CLEAR) || (state == S_RUN) ||
                   (state == S_WRITE) || (state == S_NEXT);
        err      = (state == S_ERR);
        dp_rst   = (state != S_RUN);
        out_we   = (state == S_WRITE);
        out_addr = row_sel;
    end

endmodule
